// File: rtl/muldiv_unit_pkg.sv
// Shared opcode constants for the multiply/divide unit and its pipeline neighbours.
// Holds the EXE-stage op codes consumed (or deliberately ignored) by muldiv_unit,
// plus a helper that classifies ops which occupy the unit for several cycles.
package muldiv_unit_pkg;

    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Ops that run for more than one cycle and therefore stall the pipeline.
    function automatic logic is_muldiv_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EXE-stage request/response bundle between the pipeline and the multiply/divide unit.
// master (pipeline) drives flush/start/op/a/b; slave (muldiv_unit) returns hi/lo/done/stall.
// stall is combinational from the slave and freezes the master's op/a/b while high.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [7:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;
    logic             stall;

    modport master (
        output flush, start, op, a, b,
        input  hi, lo, done, stall
    );

    modport slave (
        input  flush, start, op, a, b,
        output hi, lo, done, stall
    );
endinterface

// File: rtl/muldiv_unit_div_core.sv
// Iterative unsigned radix-2 restoring divider, one quotient bit per cycle.
// Latency: WIDTH cycles after start; valid marks the cycle whose step yields the final result.
// Ports: clk/rst/flush control; start loads dividend/divisor; quotient/remainder/valid out.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;   // shifts dividend bits out the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             busy;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        diff     = rem_sh - {1'b0, dvs};
        fits     = ~diff[WIDTH];
        rem_next = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

    // Results are the outcome of the current step so the owner can capture them
    // on the same edge that completes the last step.
    assign quotient  = quo_next;
    assign remainder = rem_next;
    assign valid     = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            quo  <= dividend;
            dvs  <= divisor;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + CW'(1);
            if (valid) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; runs MULT/MULTU/DIV/DIVU/MTHI/MTLO from EXE.
// Latency: fast MUL done at cycle 2, iterative MUL and DIV done at cycle WIDTH+1; MTHI/MTLO 1 edge.
// Ports: clk, rst (sync, active-high), bus (slave: flush/start/op/a/b in, hi/lo/done/stall out).
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MUL_ITERATIVE = 0
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplier;

    logic             op_mul;
    logic             op_div;
    logic             op_signed;
    logic             accept;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] mul_fast;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mul_res;
    logic               mul_last;
    logic               res_neg;
    logic               rem_neg;

    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_valid;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    assign op_mul    = (bus.op == EXE_MULT_OP) || (bus.op == EXE_MULTU_OP);
    assign op_div    = (bus.op == EXE_DIV_OP)  || (bus.op == EXE_DIVU_OP);
    assign op_signed = (bus.op == EXE_MULT_OP) || (bus.op == EXE_DIV_OP);
    assign accept    = (state == S_IDLE) && bus.start && !bus.flush;

    // Iterative multiply and divide both work on magnitudes; signs are restored on write-back.
    assign a_mag = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign res_neg = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign rem_neg = sgn_q && a_q[WIDTH-1];

    always_comb begin
        a_ext    = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext    = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        mul_fast = a_ext * b_ext;
        acc_next = mplier[0] ? (acc + mcand) : acc;
        if (MUL_ITERATIVE != 0) begin
            mul_res  = res_neg ? -acc_next : acc_next;
            mul_last = (cnt == CW'(WIDTH - 1));
        end else begin
            mul_res  = mul_fast;
            mul_last = 1'b1;
        end
    end

    // A zero divisor bypasses sign correction entirely: quotient all ones, remainder = dividend.
    always_comb begin
        if (b_q == '0) begin
            div_lo = '1;
            div_hi = a_q;
        end else begin
            div_lo = res_neg ? -div_quo : div_quo;
            div_hi = rem_neg ? -div_rem : div_rem;
        end
    end

    div_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .start     (accept && op_div),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        sgn_q  <= op_signed;
                        cnt    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        if (op_mul) begin
                            state <= S_MUL;
                        end else if (op_div) begin
                            state <= S_DIV;
                        end else if (bus.op == EXE_MTHI_OP) begin
                            hi_q <= bus.a;
                        end else if (bus.op == EXE_MTLO_OP) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else if (mul_last) begin
                        hi_q  <= mul_res[2*WIDTH-1:WIDTH];
                        lo_q  <= mul_res[WIDTH-1:0];
                        state <= S_DONE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                S_DIV: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else if (div_valid) begin
                        hi_q  <= div_hi;
                        lo_q  <= div_lo;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = (state == S_DONE);
    // Low in DONE so the pipeline advances on the edge that leaves DONE.
    assign bus.stall = (accept && is_muldiv_op(bus.op)) || (state == S_MUL) || (state == S_DIV);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        start_f;
    logic        start_i;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) if_f ();
    muldiv_unit_if #(.WIDTH(32)) if_i ();

    assign if_f.flush = flush;
    assign if_f.start = start_f;
    assign if_f.op    = op;
    assign if_f.a     = a;
    assign if_f.b     = b;
    assign if_i.flush = flush;
    assign if_i.start = start_i;
    assign if_i.op    = op;
    assign if_i.a     = a;
    assign if_i.b     = b;

    muldiv_unit #(.WIDTH(32), .MUL_ITERATIVE(0)) dut_f (.clk(clk), .rst(rst), .bus(if_f.slave));
    muldiv_unit #(.WIDTH(32), .MUL_ITERATIVE(1)) dut_i (.clk(clk), .rst(rst), .bus(if_i.slave));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (arithmetic + cycle countdown) ----------------
    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        longint unsigned ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'h0, x};
        uy = {32'h0, y};
        if (sgn) return sx * sy;
        return ux * uy;
    endfunction

    // returns {hi=remainder, lo=quotient}
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        int sx, sy, q, r;
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sx = $signed(x);
            sy = $signed(y);
            q = sx / sy;
            r = sx % sy;
            return {r, q};
        end
        return {x % y, x / y};
    endfunction

    logic [31:0] m_hi[2];
    logic [31:0] m_lo[2];
    logic [63:0] m_pend[2];
    int          m_left[2];
    bit          m_done[2];

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            bit st;
            st = (s == 1) ? start_i : start_f;
            if (rst) begin
                m_hi[s] = 32'h0; m_lo[s] = 32'h0; m_left[s] = 0; m_done[s] = 0;
            end else if (m_done[s]) begin
                m_done[s] = 0;
            end else if (m_left[s] > 0) begin
                if (flush) m_left[s] = 0;
                else begin
                    m_left[s]--;
                    if (m_left[s] == 0) begin
                        m_hi[s] = m_pend[s][63:32];
                        m_lo[s] = m_pend[s][31:0];
                        m_done[s] = 1;
                    end
                end
            end else if (st && !flush) begin
                if (op == EXE_MULT_OP || op == EXE_MULTU_OP) begin
                    m_pend[s] = ref_mul(op == EXE_MULT_OP, a, b);
                    m_left[s] = (s == 1) ? 32 : 1;
                end else if (op == EXE_DIV_OP || op == EXE_DIVU_OP) begin
                    m_pend[s] = ref_div(op == EXE_DIV_OP, a, b);
                    m_left[s] = 32;
                end else if (op == EXE_MTHI_OP) m_hi[s] = a;
                else if (op == EXE_MTLO_OP) m_lo[s] = a;
            end
        end
    end

    // Per-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int s = 0; s < 2; s++) begin
                bit st, exp_stall;
                st = (s == 1) ? start_i : start_f;
                exp_stall = (m_left[s] > 0) ||
                            (!m_done[s] && st && is_muldiv_op(op) && !flush);
                check(s ? "cmp_hi_iter" : "cmp_hi_fast", s ? if_i.hi : if_f.hi, m_hi[s]);
                check(s ? "cmp_lo_iter" : "cmp_lo_fast", s ? if_i.lo : if_f.lo, m_lo[s]);
                check(s ? "cmp_done_iter" : "cmp_done_fast", s ? if_i.done : if_f.done, m_done[s]);
                check(s ? "cmp_stall_iter" : "cmp_stall_fast", s ? if_i.stall : if_f.stall, exp_stall);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Issues an op at the current cycle (cycle 0), holds start until done is seen, and
    // returns in the cycle after done with start still high (caller issues next op or idles).
    task automatic run(input bit sel, input logic [7:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input int exp_cyc, input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        bit seen;
        seen = 0;
        op = o; a = aa; b = bb;
        if (sel) start_i = 1'b1; else start_f = 1'b1;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk);
            if (sel ? if_i.done : if_f.done) begin
                seen = 1;
                check({nm, "_cycle"}, cyc, exp_cyc);
                check({nm, "_hi"}, sel ? if_i.hi : if_f.hi, ehi);
                check({nm, "_lo"}, sel ? if_i.lo : if_f.lo, elo);
            end
            @(posedge clk); #1;
        end
        check({nm, "_seen_done"}, seen, 1);
    endtask

    task automatic idle();
        start_f = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic one_shot(input bit sel, input logic [7:0] o, input logic [31:0] aa);
        op = o; a = aa;
        if (sel) start_i = 1'b1; else start_f = 1'b1;
        @(posedge clk); #1;
        start_f = 1'b0;
        start_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; start_f = 1'b0; start_i = 1'b0;
        op = 8'h0; a = 32'h0; b = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", if_f.hi, 32'h0);
        check("reset_lo", if_i.lo, 32'h0);
        check("reset_done", {if_f.done, if_i.done}, 2'b00);
        check("reset_stall", {if_f.stall, if_i.stall}, 2'b00);
        chk_en = 1;
        @(posedge clk); #1;

        run(0, EXE_MULT_OP,  32'hFFFF_FFFE, 32'h3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "t1_mult_fast");
        idle();
        run(0, EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h1, "t2_multu_fast");
        idle();
        run(1, EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h1, "t2_multu_iter");
        idle();
        run(1, EXE_MULT_OP,  32'hFFFF_FFFE, 32'h3, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_iter_neg");
        idle();
        run(0, EXE_DIV_OP,   32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "t3_div_neg");
        run(0, EXE_DIVU_OP,  32'h7, 32'h2, 33, 32'h1, 32'h3, "t3_divu_b2b");
        idle();
        run(0, EXE_DIVU_OP,  32'h64, 32'h0, 33, 32'h64, 32'hFFFF_FFFF, "t4_divu_zero");
        idle();
        run(0, EXE_DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, "t4_div_min");
        idle();
        run(0, EXE_DIV_OP,   32'h7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD, "div_neg_divisor");
        idle();
        run(0, EXE_DIV_OP,   32'hFFFF_FFFB, 32'h0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_signed");
        idle();

        // MTHI, then an MTLO swallowed by flush, then ignored MFHI/MFLO
        one_shot(0, EXE_MTHI_OP, 32'hCAFE_0000);
        @(negedge clk);
        check("mthi_hi", if_f.hi, 32'hCAFE_0000);
        @(posedge clk); #1;
        flush = 1'b1;
        one_shot(0, EXE_MTLO_OP, 32'hDEAD_BEEF);
        flush = 1'b0;
        @(negedge clk);
        check("flush_mtlo_lo", if_f.lo, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        one_shot(0, EXE_MFHI_OP, 32'h1111_1111);
        one_shot(0, EXE_MFLO_OP, 32'h2222_2222);
        @(negedge clk);
        check("mfhi_mflo_ignored", {if_f.hi, if_f.lo}, {32'hCAFE_0000, 32'hFFFF_FFFF});
        @(posedge clk); #1;

        // t5: flush an in-flight DIV at cycle 10, MTLO follows at cycle 11
        op = EXE_DIV_OP; a = 32'd100; b = 32'd7; start_f = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check("t5_stall_c10", if_f.stall, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0; op = EXE_MTLO_OP; a = 32'h1234;
        @(negedge clk);
        check("t5_stall_c11", if_f.stall, 1'b0);
        check("t5_done_c11", if_f.done, 1'b0);
        check("t5_hilo_c11", {if_f.hi, if_f.lo}, {32'hCAFE_0000, 32'hFFFF_FFFF});
        @(posedge clk); #1;
        start_f = 1'b0;
        @(negedge clk);
        check("t5_lo_c12", if_f.lo, 32'h1234);
        repeat (40) begin @(posedge clk); #1; end

        // t6: MTHI 5, iterative MULT, rst at cycle 5
        one_shot(1, EXE_MTHI_OP, 32'h5);
        @(negedge clk);
        check("t6_mthi", if_i.hi, 32'h5);
        @(posedge clk); #1;
        op = EXE_MULT_OP; a = 32'h3; b = 32'h4; start_i = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        check("t6_stall_c5", if_i.stall, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check("t6_after_rst", {if_i.hi, if_i.lo, if_i.done, if_i.stall}, 66'h0);
        @(posedge clk); #1;

        run(1, EXE_DIVU_OP, 32'h7, 32'h2, 33, 32'h1, 32'h3, "divu_iter_after_rst");
        run(1, EXE_DIV_OP,  32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_iter_b2b");
        idle();
        repeat (3) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
